// File: rtl/wb_debug_defs.sv
// rtl/wb_debug_defs.sv - shared state encodings and defaults for the Wishbone debug master
package wb_debug_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int          CNT_W           = 16;
    localparam logic [31:0] ADR_WORD_MASK   = 32'hFFFF_FFFC;

endpackage

// File: rtl/wb_debug_master.sv
// rtl/wb_debug_master.sv - single-outstanding command to Wishbone classic master with ack timeout
module wb_debug_master
    import wb_debug_defs::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_timeout,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    wb_state_t        r_state;
    wb_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_cmd_ready;
    logic             w_cmd_ready_nxt;
    logic             r_cyc;
    logic             w_cyc_nxt;
    logic             r_we;
    logic             w_we_nxt;
    logic [31:0]      r_adr;
    logic [31:0]      w_adr_nxt;
    logic [31:0]      r_dat;
    logic [31:0]      w_dat_nxt;
    logic [3:0]       r_sel;
    logic [3:0]       w_sel_nxt;
    logic             r_rsp_valid;
    logic             w_rsp_valid_nxt;
    logic [31:0]      r_rsp_dat;
    logic [31:0]      w_rsp_dat_nxt;
    logic             r_rsp_timeout;
    logic             w_rsp_timeout_nxt;

    // Wait counter saturates instead of wrapping
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    // Next-state and next-output logic; ack is only looked at while in BUS
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_cyc_nxt         = r_cyc;
        w_we_nxt          = r_we;
        w_adr_nxt         = r_adr;
        w_dat_nxt         = r_dat;
        w_sel_nxt         = r_sel;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_dat_nxt     = r_rsp_dat;
        w_rsp_timeout_nxt = r_rsp_timeout;
        case (r_state)
            IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_state_nxt = BUS;
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = cmd_we;
                    w_adr_nxt   = cmd_adr & ADR_WORD_MASK;
                    w_dat_nxt   = cmd_dat;
                    w_sel_nxt   = cmd_sel;
                    w_cnt_nxt   = '0;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    // Ack wins even on the cycle the counter would expire
                    w_state_nxt       = RESP;
                    w_cyc_nxt         = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_dat_nxt     = r_we ? 32'd0 : wbm_dat_i;
                    w_rsp_timeout_nxt = 1'b0;
                end else if (w_cnt_inc >= TIMEOUT_CNT) begin
                    w_state_nxt       = RESP;
                    w_cnt_nxt         = w_cnt_inc;
                    w_cyc_nxt         = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_dat_nxt     = 32'd0;
                    w_rsp_timeout_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_cyc_nxt       = 1'b0;
                w_rsp_valid_nxt = 1'b0;
            end
        endcase
        w_cmd_ready_nxt = (w_state_nxt == IDLE);
    end

    // State and registered outputs; reset drops the bus cycle without waiting for a clock
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b0;
            r_cyc         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= 32'd0;
            r_dat         <= 32'd0;
            r_sel         <= 4'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_dat     <= 32'd0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_cyc         <= w_cyc_nxt;
            r_we          <= w_we_nxt;
            r_adr         <= w_adr_nxt;
            r_dat         <= w_dat_nxt;
            r_sel         <= w_sel_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_dat     <= w_rsp_dat_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_dat     = r_rsp_dat;
    assign rsp_timeout = r_rsp_timeout;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;

endmodule

// File: tb/tb_wb_debug_master.sv
// tb/tb_wb_debug_master.sv - directed scoreboard bench for wb_debug_master
module tb_wb_debug_master;

    localparam int unsigned TO = 4;

    logic        wb_clk_i = 1'b0;
    logic        wb_rstn_i = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_timeout;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = 32'd0;

    typedef struct packed {
        logic [31:0] dat;
        logic        to;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad = 0;

    wb_debug_master #(.TIMEOUT(TO)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rstn_i   (wb_rstn_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_adr     (cmd_adr),
        .cmd_dat     (cmd_dat),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_dat     (rsp_dat),
        .rsp_timeout (rsp_timeout),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    // Issue one command, play the slave (ack on stb cycle ack_at, 0 = never),
    // hold rsp_ready low for hold cycles while offering another command, then consume.
    task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int ack_at, input logic [31:0] sdat,
                           input int hold);
        int   n;
        int   stb_cycles;
        rsp_t e;
        rsp_t got;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        e.dat = (we || ack_at == 0) ? 32'd0 : sdat;
        e.to  = (ack_at == 0);
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        chk("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
        chk("wbm_adr", wbm_adr_o, adr & 32'hFFFF_FFFC);
        chk("wbm_we", 32'(wbm_we_o), 32'(we));
        chk("wbm_dat", wbm_dat_o, dat);
        chk("wbm_sel", 32'(wbm_sel_o), 32'(sel));
        stb_cycles = 0;
        while (wbm_cyc_o === 1'b1 && stb_cycles < 40) begin
            chk("wbm_stb_with_cyc", 32'(wbm_stb_o), 32'd1);
            chk("wbm_adr_stable", wbm_adr_o, adr & 32'hFFFF_FFFC);
            stb_cycles++;
            if (ack_at != 0 && stb_cycles == ack_at) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = sdat;
            end else begin
                wbm_ack_i = 1'b0;
                wbm_dat_i = $urandom;
            end
            tick();
        end
        wbm_ack_i = 1'b0;
        chk("stb_cycles", 32'(stb_cycles), (ack_at != 0) ? 32'(ack_at) : 32'(TO));
        chk("stb_low_after_cycle", 32'(wbm_stb_o), 32'd0);
        chk("rsp_valid_on_drop", 32'(rsp_valid), 32'd1);
        got.dat = rsp_dat;
        got.to  = rsp_timeout;
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_adr   = 32'hBAD0_0000;
            tick();
            chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
            chk("rsp_valid_held", 32'(rsp_valid), 32'd1);
            chk("rsp_dat_stable", rsp_dat, got.dat);
            chk("rsp_to_stable", 32'(rsp_timeout), 32'(got.to));
            chk("no_cyc_in_resp", 32'(wbm_cyc_o), 32'd0);
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_dat", rsp_dat, e.dat);
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_after_consume", 32'(rsp_valid), 32'd0);
        chk("cmd_ready_back_in_idle", 32'(cmd_ready), 32'd1);
        chk("no_cyc_at_handshake", 32'(wbm_cyc_o), 32'd0);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rsp_t dropped;
        tick();
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'd0);
        chk("rst_dat", wbm_dat_o, 32'd0);
        chk("rst_sel", 32'(wbm_sel_o), 32'd0);

        wb_rstn_i = 1'b1;
        chk("cmd_ready_before_first_clk", 32'(cmd_ready), 32'd0);
        tick();
        chk("cmd_ready_first_clk", 32'(cmd_ready), 32'd1);

        wbm_ack_i = 1'b1;
        wbm_dat_i = 32'h5555_AAAA;
        tick();
        wbm_ack_i = 1'b0;
        chk("stray_ack_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stray_ack_cyc", 32'(wbm_cyc_o), 32'd0);

        run_cmd(1'b1, 32'h3000_0006, 32'hDEAD_BEEF, 4'hF, 3, 32'hCAFE_F00D, 0);
        run_cmd(1'b0, 32'h3000_0000, 32'h0,        4'hF, 1, 32'h1234_5678, 0);
        run_cmd(1'b0, 32'h3000_0010, 32'h0,        4'h3, 0, 32'h0,         0);
        run_cmd(1'b0, 32'h3000_0008, 32'h0,        4'hF, 2, 32'hA5A5_5A5A, 10);
        run_cmd(1'b0, 32'h4000_000F, 32'h0,        4'hC, 4, 32'h0BAD_CAFE, 0);

        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h5000_0000;
        cmd_dat   = 32'h0102_0304;
        cmd_sel   = 4'hF;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("mid_bus_cyc_high", 32'(wbm_cyc_o), 32'd1);
        #2 wb_rstn_i = 1'b0;
        #1;
        chk("async_rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("async_rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge wb_clk_i);
        chk("in_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        wb_rstn_i = 1'b1;
        tick();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        chk("post_rst_no_cyc", 32'(wbm_cyc_o), 32'd0);

        run_cmd(1'b0, 32'h3000_0024, 32'h0, 4'h1, 2, 32'h7777_0001, 0);
        run_cmd(1'b1, 32'h3000_0025, 32'hFFFF_0000, 4'h2, 1, 32'h9999_9999, 1);

        if (sb.size() != 0) begin
            dropped = sb.pop_front();
            chk("scoreboard_leftover", 32'(sb.size() + 1), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_debug_master.md
WB_DEBUG_MASTER -- requirements
Module: wb_debug_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting for wbm_ack_i before aborting (1..65535).
REQ-002 SHALL have port wb_clk_i  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port wb_rstn_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  command request.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-006 SHALL have port cmd_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_adr  input  32  byte address.
REQ-008 SHALL have port cmd_dat  input  32  write data.
REQ-009 SHALL have port cmd_sel  input  4  byte enables.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-012 SHALL have port rsp_dat  output  32  read data; 0 for writes and timeouts.
REQ-013 SHALL have port rsp_timeout  output  1  1 = no ack within TIMEOUT cycles.
REQ-014 SHALL have ports wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone classic master controls.
REQ-015 SHALL have ports wbm_adr_o  output  32, wbm_dat_o  output  32, wbm_sel_o  output  4  Wishbone address/data/select.
REQ-016 SHALL have ports wbm_ack_i  input  1, wbm_dat_i  input  32  Wishbone slave response.

Function
REQ-017 SHALL implement FSM states IDLE, BUS, RESP.
REQ-018 IDLE: cmd_ready = 1 only in IDLE; all other outputs registered.
REQ-019 IDLE -> BUS on accepted command: cmd_we/adr/dat/sel latched into wbm_we_o/adr_o/dat_o/sel_o; wbm_cyc_o = wbm_stb_o = 1 from next cycle.
REQ-020 wbm_adr_o SHALL be cmd_adr with bits [1:0] forced to 0.
REQ-021 BUS: wbm_* held stable until ack or timeout; wait counter increments each BUS cycle without ack.
REQ-022 wbm_ack_i in BUS -> drop wbm_cyc_o/wbm_stb_o next cycle, capture wbm_dat_i into rsp_dat (read) or 0 (write), rsp_timeout = 0, go RESP.
REQ-023 Counter reaching TIMEOUT without ack -> drop cyc/stb, rsp_dat = 0, rsp_timeout = 1, go RESP.
REQ-024 Ack in the same cycle the counter reaches TIMEOUT SHALL count as ack (rsp_timeout = 0).
REQ-025 wbm_ack_i outside BUS SHALL be ignored.
REQ-026 RESP: rsp_valid = 1, rsp_dat/rsp_timeout stable until rsp_ready; then rsp_valid = 0 and go IDLE next cycle.
REQ-027 Minimum command-to-response latency: 2 cycles with slave acking in the first stb cycle (accept edge, ack edge -> rsp_valid).
REQ-028 Exactly one Wishbone cycle per command; no back-to-back overlap; new command accepted only in IDLE.
REQ-029 Counter SHALL be 16 bits, cleared on entry to BUS, never wraps.

Reset
REQ-030 wb_rstn_i low SHALL immediately force IDLE, cmd_ready = 0 during reset, rsp_valid = 0, rsp_dat = 0, rsp_timeout = 0, wbm_cyc_o = wbm_stb_o = wbm_we_o = 0, wbm_adr_o = wbm_dat_o = 0, wbm_sel_o = 0, counter = 0.
REQ-031 Reset asserted mid-BUS SHALL abandon the cycle (cyc/stb low asynchronously) with no response produced.
REQ-032 cmd_ready SHALL rise in the first clock after reset release.

Structure
REQ-033 State encodings (IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2) and the default TIMEOUT value SHALL reside in shared header wb_debug_defs.
REQ-034 Single flat module; no sub-modules; counter and FSM inline.

Verification
REQ-035 Write adr 0x3000_0006, dat 0xDEADBEEF, sel 0xF, slave acks after 3 cycles -> wbm_adr_o = 0x3000_0004, cyc/stb high 3 cycles, rsp_valid with rsp_dat = 0, rsp_timeout = 0.
REQ-036 Read adr 0x3000_0000, slave returns 0x1234_5678 with ack in first stb cycle -> rsp_valid 2 cycles after accept, rsp_dat = 0x1234_5678.
REQ-037 TIMEOUT = 4, slave never acks -> cyc/stb high exactly 4 cycles, rsp_timeout = 1, rsp_dat = 0.
REQ-038 rsp_ready held low 10 cycles, cmd_valid high with new command -> cmd_ready stays 0, response stable, second command accepted only after IDLE.
REQ-039 wb_rstn_i pulsed low during BUS -> cyc/stb drop without clock, no rsp_valid, next command after release completes normally.
REQ-040 TIMEOUT = 4, ack on 4th wait cycle -> rsp_timeout = 0, ack data captured.
